// File: rtl/ssd_scan_mux_pkg.sv
// Shared types and helpers for the seven-segment scan multiplexer.
// lz_mask is only consumed when SSD_LZB_EN (leading-zero blanking) is defined.
package ssd_pkg;

  typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_e;
  typedef logic [3:0] nibble_t;

  // Sized for the widest legal display; users slice to NUM_DIGITS.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Lit mask: digits up to the highest nonzero nibble; digit 0 always lit.
  function automatic logic [7:0] lz_mask(input logic [31:0] shadow, input int num_digits);
    int hi;
    hi = 0;
    for (int i = 0; i < 8; i++)
      if (i < num_digits && shadow[4*i +: 4] != 4'h0) hi = i;
    for (int i = 0; i < 8; i++)
      lz_mask[i] = (i <= hi);
  endfunction

endpackage

// File: rtl/ssd_scan_mux_timer.sv
// Phase counter for the scan FSM: length chosen by the current phase,
// synchronous clear, combinational terminal count.
module ssd_scan_timer #(
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter int CW          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic show,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (show ? CW'(SHOW_CYCLES - 1) : CW'(GAP_CYCLES - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (tc)       cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// N-digit common-anode scan multiplexer with frame-synchronous value update.
// Define SSD_LZB_EN to blank leading-zero digits during their SHOW slot.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic                          enable,
  output logic [3:0]                    digit,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int VW   = 4 * NUM_DIGITS;
  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e                state_q, state_n;
  logic [IW-1:0]         idx_n;
  logic [VW-1:0]         shadow_q, shadow_n, pending_q;
  logic                  pv_q;
  logic                  tc, boundary;
  nibble_t               digit_n;
  logic [NUM_DIGITS-1:0] anode_n;

  ssd_scan_timer #(
    .SHOW_CYCLES(SHOW_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .CW         (CW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!enable),
    .show (state_q == SHOW),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= GAP;
      digit_idx <= '0;
    end else begin
      state_q   <= state_n;
      digit_idx <= idx_n;
    end
  end

  // Disable parks the FSM in GAP without touching the digit index.
  always_comb begin
    state_n  = state_q;
    idx_n    = digit_idx;
    boundary = 1'b0;
    if (!enable) begin
      state_n = GAP;
    end else if (tc) begin
      case (state_q)
        GAP:  state_n = SHOW;
        SHOW: begin
          state_n = GAP;
          if (digit_idx == IW'(NUM_DIGITS - 1)) begin
            idx_n    = '0;
            boundary = 1'b1;
          end else begin
            idx_n = digit_idx + IW'(1);
          end
        end
        default: state_n = GAP;
      endcase
    end
  end

  // A load coinciding with the boundary bypasses pending straight into shadow.
  always_comb begin
    shadow_n = shadow_q;
    if (boundary) begin
      if (load)      shadow_n = value;
      else if (pv_q) shadow_n = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      pending_q <= '0;
      pv_q      <= 1'b0;
    end else begin
      shadow_q <= shadow_n;
      if (load) pending_q <= value;
      if (boundary)  pv_q <= 1'b0;
      else if (load) pv_q <= 1'b1;
    end
  end

`ifdef SSD_LZB_EN
  logic [31:0] shadow_w;
  logic [7:0]  lit;
  always_comb begin
    shadow_w         = '0;
    shadow_w[VW-1:0] = shadow_n;
    lit              = lz_mask(shadow_w, NUM_DIGITS);
  end
`endif

  // Outputs are computed from next-state values so the flops line up with the FSM.
  always_comb begin
    digit_n = shadow_n[{idx_n, 2'b00} +: 4];
    anode_n = ANODE_OFF[NUM_DIGITS-1:0];
    if (state_n == SHOW) begin
`ifdef SSD_LZB_EN
      anode_n[idx_n] = ~lit[idx_n];
`else
      anode_n[idx_n] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit      <= 4'h0;
      anode      <= ANODE_OFF[NUM_DIGITS-1:0];
      frame_done <= 1'b0;
    end else begin
      digit      <= digit_n;
      anode      <= anode_n;
      frame_done <= boundary;
    end
  end

endmodule
